// File: rtl/cpu_bus_seq.sv
// rtl/cpu_bus_seq.sv - multi-beat request/done memory access sequencer for the 6502 RAM port
module cpu_bus_seq #(
    parameter int AW   = 16,
    parameter int DW   = 8,
    parameter int MAXB = 2,
    parameter int WAIT = 0,
    parameter int LW   = $clog2(MAXB + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [LW-1:0]       len,
    input  logic                wrap_page,
    input  logic [MAXB*DW-1:0]  wdata,
    output logic                busy,
    output logic                done,
    output logic [MAXB*DW-1:0]  rdata,
    output logic [AW-1:0]       address,
    input  logic [DW-1:0]       i_data,
    output logic [DW-1:0]       o_data,
    output logic                wren,
    output logic                read
);

    localparam int KW = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [KW-1:0]       last_q, last_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic                we_q, we_d;
    logic                wrap_q, wrap_d;
    logic [AW-1:0]       base_q, base_d;
    logic [MAXB*DW-1:0]  wdata_q, wdata_d;
    logic [MAXB*DW-1:0]  rdata_q, rdata_d;
    logic [AW-1:0]       address_q, address_d;
    logic [DW-1:0]       o_data_q, o_data_d;
    logic                wren_q, wren_d;
    logic                read_q, read_d;
    logic                done_q, done_d;
    logic [KW-1:0]       kn;
    logic [KW-1:0]       eff_last;

    // Page wrap keeps the high address bits and rolls only the low byte.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base,
                                                input logic wrap, input logic [KW-1:0] k);
        logic [7:0] lo;
        lo = base[7:0] + 8'(k);
        if (wrap)
            beat_addr = {base[AW-1:8], lo};
        else
            beat_addr = base + AW'(k);
    endfunction

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        wcnt_d    = wcnt_q;
        we_d      = we_q;
        wrap_d    = wrap_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        address_d = address_q;
        o_data_d  = o_data_q;
        wren_d    = wren_q;
        read_d    = read_q;
        done_d    = 1'b0;
        kn        = k_q + KW'(1);

        if (len == '0)
            eff_last = '0;
        else if (len > LW'(MAXB))
            eff_last = KW'(MAXB - 1);
        else
            eff_last = KW'(len - LW'(1));

        case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                read_d = 1'b0;
                if (req) begin
                    we_d      = we;
                    base_d    = addr;
                    last_d    = eff_last;
                    wrap_d    = wrap_page;
                    wdata_d   = wdata;
                    rdata_d   = '0;
                    k_d       = '0;
                    wcnt_d    = '0;
                    address_d = addr;
                    state_d   = ADDR;
                    if (we) begin
                        wren_d   = 1'b1;
                        o_data_d = wdata[DW-1:0];
                    end else begin
                        read_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (wcnt_q != CW'(WAIT)) begin
                    wcnt_d = wcnt_q + CW'(1);
                end else begin
                    wcnt_d = '0;
                    if (!we_q) begin
                        read_d  = 1'b0;
                        state_d = DATA;
                    end else if (k_q == last_q) begin
                        wren_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        k_d       = kn;
                        address_d = beat_addr(base_q, wrap_q, kn);
                        o_data_d  = wdata_q[kn*DW +: DW];
                    end
                end
            end
            DATA: begin
                rdata_d[k_q*DW +: DW] = i_data;
                if (k_q == last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d       = kn;
                    address_d = beat_addr(base_q, wrap_q, kn);
                    read_d    = 1'b1;
                    state_d   = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_q    <= '0;
            wcnt_q    <= '0;
            we_q      <= 1'b0;
            wrap_q    <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            address_q <= '0;
            o_data_q  <= '0;
            wren_q    <= 1'b0;
            read_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            wcnt_q    <= wcnt_d;
            we_q      <= we_d;
            wrap_q    <= wrap_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            address_q <= address_d;
            o_data_q  <= o_data_d;
            wren_q    <= wren_d;
            read_q    <= read_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign address = address_q;
    assign o_data  = o_data_q;
    assign wren    = wren_q;
    assign read    = read_q;

endmodule
